// File: rtl/can_timing_pkg.sv
// Shared bit-timing definitions: segment encoding, counter widths and segment-length helpers.
package can_timing_pkg;

    localparam int SEG_W    = 2;
    localparam int QCNT_W   = 5;
    localparam int SEGLEN_W = 4;

    typedef enum logic [SEG_W-1:0] {
        SEG_SYNC = 2'b00,
        SEG_PROP = 2'b01,
        SEG_PS1  = 2'b10,
        SEG_PS2  = 2'b11
    } seg_e;

    typedef struct packed {
        logic [SEGLEN_W-1:0] prop;
        logic [SEGLEN_W-1:0] ps1;
        logic [SEGLEN_W-1:0] ps2;
    } seg_cfg_t;

    // Phase segments programmed as 0 still occupy one quantum.
    function automatic logic [QCNT_W-1:0] phase_len(input logic [SEGLEN_W-1:0] len);
        return (len == '0) ? QCNT_W'(1) : QCNT_W'(len);
    endfunction

endpackage

// File: rtl/bit_segment_sequencer_if.sv
// Signal bundle between a bit-timing controller (master) and the segment sequencer (slave).
interface bit_segment_sequencer_if #(
    parameter int PRESC_W = 6
);
    import can_timing_pkg::*;

    logic                enable;
    logic [PRESC_W-1:0]  baud_prescaler;
    logic [SEGLEN_W-1:0] prop_seg;
    logic [SEGLEN_W-1:0] phase_seg1;
    logic [SEGLEN_W-1:0] phase_seg2;
    logic                hard_sync_request;
    logic                resync_required;
    logic [SEGLEN_W-1:0] resync_adjustment;
    logic                resync_direction;
    logic                tq_tick;
    logic [SEG_W-1:0]    current_segment;
    logic [QCNT_W-1:0]   quanta_counter;
    logic [QCNT_W-1:0]   bit_position;
    logic                sample_point;
    logic                bit_start;

    modport master (
        output enable, baud_prescaler, prop_seg, phase_seg1, phase_seg2,
               hard_sync_request, resync_required, resync_adjustment, resync_direction,
        input  tq_tick, current_segment, quanta_counter, bit_position, sample_point, bit_start
    );

    modport slave (
        input  enable, baud_prescaler, prop_seg, phase_seg1, phase_seg2,
               hard_sync_request, resync_required, resync_adjustment, resync_direction,
        output tq_tick, current_segment, quanta_counter, bit_position, sample_point, bit_start
    );

endinterface

// File: rtl/tq_prescaler.sv
// Time-quantum prescaler: counts 0..prescaler and emits a tick on the last count.
module tq_prescaler #(
    parameter int PRESC_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescaler,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    // A clear restarts the quantum, so the tick it would have produced is dropped.
    assign tick = enable && !clear && (cnt_q == prescaler);

    always_comb begin
        cnt_d = cnt_q + PRESC_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_segment_sequencer.sv
// Bit-timing sequencer: walks SYNC/PROP/PS1/PS2 in time quanta and applies hard and soft resync.
module bit_segment_sequencer
    import can_timing_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [PRESC_W-1:0]  baud_prescaler,
    input  logic [SEGLEN_W-1:0] prop_seg,
    input  logic [SEGLEN_W-1:0] phase_seg1,
    input  logic [SEGLEN_W-1:0] phase_seg2,
    input  logic                hard_sync_request,
    input  logic                resync_required,
    input  logic [SEGLEN_W-1:0] resync_adjustment,
    input  logic                resync_direction,
    output logic                tq_tick,
    output logic [SEG_W-1:0]    current_segment,
    output logic [QCNT_W-1:0]   quanta_counter,
    output logic [QCNT_W-1:0]   bit_position,
    output logic                sample_point,
    output logic                bit_start
);

    seg_e                state_q;
    seg_e                state_d;
    logic [QCNT_W-1:0]   qcnt_q;
    logic [QCNT_W-1:0]   bitpos_q;
    logic [SEGLEN_W-1:0] ext_q;
    logic                ext_taken_q;
    logic [SEGLEN_W-1:0] short_q;
    logic                short_taken_q;
    logic                end_now_q;
    logic                start_pend_q;
    seg_cfg_t            cfg_q;
    logic [PRESC_W-1:0]  presc_q;
    logic                tq_tick_q;
    logic                sample_q;
    logic                bit_start_q;

    logic              tick;
    logic              restart;
    logic              seg_end;
    logic              enter_sync;
    logic              lengthen_ok;
    logic              shorten_ok;
    logic              shorten_end;
    logic [QCNT_W-1:0] ps2_nom;
    logic [QCNT_W-1:0] remaining;
    logic [QCNT_W-1:0] seg_len;

    // The first enabled clock after reset behaves exactly like a hard sync.
    assign restart = enable && (hard_sync_request || start_pend_q);

    tq_prescaler #(.PRESC_W(PRESC_W)) u_tq_prescaler (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (restart),
        .prescaler (presc_q),
        .tick      (tick)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        seg_len   = QCNT_W'(1);
        ps2_nom   = phase_len(cfg_q.ps2);
        remaining = ps2_nom - qcnt_q - QCNT_W'(1);
        unique case (state_q)
            SEG_SYNC: state_d = (cfg_q.prop == '0) ? SEG_PS1 : SEG_PROP;
            SEG_PROP: begin
                seg_len = QCNT_W'(cfg_q.prop);
                state_d = SEG_PS1;
            end
            SEG_PS1: begin
                seg_len = phase_len(cfg_q.ps1) + QCNT_W'(ext_q);
                state_d = SEG_PS2;
            end
            SEG_PS2: begin
                seg_len = ps2_nom - QCNT_W'(short_q);
                state_d = SEG_SYNC;
            end
        endcase
        seg_end     = tick && ((qcnt_q == seg_len - QCNT_W'(1)) ||
                               (state_q == SEG_PS2 && end_now_q));
        enter_sync  = restart || (seg_end && state_q == SEG_PS2);
        lengthen_ok = resync_required && !resync_direction && !ext_taken_q &&
                      (state_q == SEG_PROP || state_q == SEG_PS1);
        shorten_ok  = resync_required && resync_direction && !short_taken_q &&
                      (state_q == SEG_PS2);
        shorten_end = QCNT_W'(resync_adjustment) >= remaining;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= SEG_SYNC;
            qcnt_q        <= '0;
            bitpos_q      <= '0;
            ext_q         <= '0;
            ext_taken_q   <= 1'b0;
            short_q       <= '0;
            short_taken_q <= 1'b0;
            end_now_q     <= 1'b0;
            start_pend_q  <= 1'b1;
            cfg_q         <= '0;
            presc_q       <= '0;
            tq_tick_q     <= 1'b0;
            sample_q      <= 1'b0;
            bit_start_q   <= 1'b0;
        end else if (!enable) begin
            tq_tick_q   <= 1'b0;
            sample_q    <= 1'b0;
            bit_start_q <= 1'b0;
        end else begin
            tq_tick_q   <= tick;
            sample_q    <= 1'b0;
            bit_start_q <= 1'b0;
            if (lengthen_ok) begin
                ext_q       <= resync_adjustment;
                ext_taken_q <= 1'b1;
            end
            if (shorten_ok) begin
                short_taken_q <= 1'b1;
                if (shorten_end) begin
                    end_now_q <= 1'b1;
                end else begin
                    short_q <= resync_adjustment;
                end
            end
            if (tick) begin
                qcnt_q   <= qcnt_q + QCNT_W'(1);
                bitpos_q <= bitpos_q + QCNT_W'(1);
            end
            if (seg_end) begin
                state_q  <= state_d;
                qcnt_q   <= '0;
                sample_q <= (state_q == SEG_PS1);
            end
            // Bit boundary: later assignments here override any resync latched this clock.
            if (enter_sync) begin
                state_q       <= SEG_SYNC;
                qcnt_q        <= '0;
                bitpos_q      <= '0;
                ext_q         <= '0;
                ext_taken_q   <= 1'b0;
                short_q       <= '0;
                short_taken_q <= 1'b0;
                end_now_q     <= 1'b0;
                start_pend_q  <= 1'b0;
                cfg_q         <= '{prop: prop_seg, ps1: phase_seg1, ps2: phase_seg2};
                presc_q       <= baud_prescaler;
                sample_q      <= 1'b0;
                bit_start_q   <= 1'b1;
            end
        end
    end

    assign tq_tick         = tq_tick_q;
    assign current_segment = state_q;
    assign quanta_counter  = qcnt_q;
    assign bit_position    = bitpos_q;
    assign sample_point    = sample_q;
    assign bit_start       = bit_start_q;

endmodule
